spmv_lane: RTL and testbench

Parametrised SpMV processing lane: accepts one nonzero (value, column) per cycle from the matrix arbiter, issues the column to the banked vector buffer (BVB), multiplies through a configurable-depth pipeline, and accumulates per row. Each completed row sum is emitted to the output-vector writer. The lane also buffers row lengths for the CISR decoder. It replaces the fixed 4-stage channel with parametrised multiplier depth, valid/ready input handshake, correct first-row handling, and an end-of-stream flush of the final row.

---
 rtl/spmv_lane_if.sv | 32 +++
 rtl/spmv_lane.sv | 244 ++++++++++++++++++++++++
 tb/tb_spmv_lane.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/spmv_lane_if.sv
// Bus bundle for spmv_lane: arbiter nonzero input, BVB fetch/return pair and row-sum output.
interface spmv_lane_if #(
  parameter int DATA_W = 32,
  parameter int DIM_W  = 10
);
  // A nonzero transfers on every rising clk edge where in_valid && in_ready are both high;
  // while in_valid is high and in_ready low, the source holds in_val/in_col/in_last stable.
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_val;
  logic [DIM_W-1:0]  in_col;
  logic              in_last;

  logic [DIM_W-1:0]  col_out;
  logic              col_out_valid;
  logic [DATA_W-1:0] bvb_val;
  logic [DIM_W-1:0]  dec_row_id;

  logic              out_valid;
  logic [DIM_W-1:0]  out_row;
  logic [DATA_W-1:0] out_sum;

  modport master (
    output in_valid, in_val, in_col, in_last, bvb_val, dec_row_id,
    input  in_ready, col_out, col_out_valid, out_valid, out_row, out_sum
  );

  modport slave (
    input  in_valid, in_val, in_col, in_last, bvb_val, dec_row_id,
    output in_ready, col_out, col_out_valid, out_valid, out_row, out_sum
  );
endinterface

// File: rtl/spmv_lane.sv
// SpMV lane: fetch -> MUL_STAGES multiplier pipe -> per-row accumulator, plus row-length FIFO.
// Define SPMV_LANE_SAT_EN for saturating product/accumulation instead of wrapping arithmetic.
module spmv_lane #(
  parameter int DATA_W     = 32,
  parameter int DIM_W      = 10,
  parameter int MUL_STAGES = 4,
  parameter int RL_DEPTH   = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              spmv_init,
  spmv_lane_if.slave        bus,
  input  logic              rl_push,
  input  logic [DATA_W-1:0] rl_data,
  input  logic              rl_pop,
  output logic [DATA_W-1:0] rl_head,
  output logic              rl_empty,
  output logic              rl_full,
  output logic              done,
  output logic [1:0]        dbg_state
);
  localparam int AW = $clog2(RL_DEPTH);

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_DRAIN = 2'd1,
    S_FLUSH = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t state_q, state_d;
  logic   run_ready;
  logic   accept;

  logic              f_valid;
  logic [DIM_W-1:0]  f_col;
  logic [DATA_W-1:0] f_val;
  logic              f_last;

  logic              p_valid [MUL_STAGES];
  logic [DATA_W-1:0] p_prod  [MUL_STAGES];
  logic [DIM_W-1:0]  p_row   [MUL_STAGES];
  logic              p_last  [MUL_STAGES];

  logic              q_valid;
  logic [DATA_W-1:0] q_prod;
  logic [DIM_W-1:0]  q_row;
  logic              q_last;

  logic              acc_live;
  logic [DATA_W-1:0] acc_sum;
  logic [DIM_W-1:0]  acc_row;

  logic              out_valid_q;
  logic [DIM_W-1:0]  out_row_q;
  logic [DATA_W-1:0] out_sum_q;

  logic [DATA_W-1:0] mul_res;
  logic [DATA_W-1:0] add_res;

`ifdef SPMV_LANE_SAT_EN
  localparam logic [DATA_W-1:0] S_MAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] S_MIN = {1'b1, {(DATA_W-1){1'b0}}};

  logic signed [2*DATA_W-1:0] mul_full;
  logic signed [DATA_W:0]     add_full;

  assign mul_full = $signed(f_val) * $signed(bus.bvb_val);
  assign add_full = $signed({acc_sum[DATA_W-1], acc_sum}) + $signed({q_prod[DATA_W-1], q_prod});

  always_comb begin
    mul_res = mul_full[DATA_W-1:0];
    if (mul_full > $signed({{DATA_W{1'b0}}, S_MAX})) mul_res = S_MAX;
    else if (mul_full < $signed({{DATA_W{1'b1}}, S_MIN})) mul_res = S_MIN;
  end

  // A carry into the guard bit that disagrees with the sign bit means overflow.
  always_comb begin
    add_res = add_full[DATA_W-1:0];
    if (add_full[DATA_W] != add_full[DATA_W-1]) add_res = add_full[DATA_W] ? S_MIN : S_MAX;
  end
`else
  assign mul_res = f_val * bus.bvb_val;
  assign add_res = acc_sum + q_prod;
`endif

  assign bus.in_ready      = run_ready && !spmv_init;
  assign accept            = bus.in_valid && bus.in_ready;
  assign bus.col_out       = f_col;
  assign bus.col_out_valid = f_valid;
  assign bus.out_valid     = out_valid_q;
  assign bus.out_row       = out_row_q;
  assign bus.out_sum       = out_sum_q;
  assign dbg_state         = state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_RUN;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    run_ready = 1'b0;
    case (state_q)
      S_RUN: begin
        run_ready = 1'b1;
        if (accept && bus.in_last) state_d = S_DRAIN;
      end
      S_DRAIN: if (q_valid && q_last) state_d = S_FLUSH;
      S_FLUSH: state_d = S_DONE;
      S_DONE:  state_d = S_DONE;
      default: state_d = S_RUN;
    endcase
    if (spmv_init) state_d = S_RUN;
  end

  // Valid bits always advance; payload registers only load behind a valid element.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f_valid <= 1'b0;
      f_col   <= '0;
      f_val   <= '0;
      f_last  <= 1'b0;
      for (int i = 0; i < MUL_STAGES; i++) begin
        p_valid[i] <= 1'b0;
        p_prod[i]  <= '0;
        p_row[i]   <= '0;
        p_last[i]  <= 1'b0;
      end
      q_valid <= 1'b0;
      q_prod  <= '0;
      q_row   <= '0;
      q_last  <= 1'b0;
    end else if (spmv_init) begin
      f_valid <= 1'b0;
      f_col   <= '0;
      for (int i = 0; i < MUL_STAGES; i++) p_valid[i] <= 1'b0;
      q_valid <= 1'b0;
    end else begin
      f_valid <= accept;
      if (accept) begin
        f_col  <= bus.in_col;
        f_val  <= bus.in_val;
        f_last <= bus.in_last;
      end
      p_valid[0] <= f_valid;
      if (f_valid) begin
        p_prod[0] <= mul_res;
        p_row[0]  <= bus.dec_row_id;
        p_last[0] <= f_last;
      end
      for (int i = 1; i < MUL_STAGES; i++) begin
        p_valid[i] <= p_valid[i-1];
        if (p_valid[i-1]) begin
          p_prod[i] <= p_prod[i-1];
          p_row[i]  <= p_row[i-1];
          p_last[i] <= p_last[i-1];
        end
      end
      q_valid <= p_valid[MUL_STAGES-1];
      if (p_valid[MUL_STAGES-1]) begin
        q_prod <= p_prod[MUL_STAGES-1];
        q_row  <= p_row[MUL_STAGES-1];
        q_last <= p_last[MUL_STAGES-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_live    <= 1'b0;
      acc_sum     <= '0;
      acc_row     <= '0;
      out_valid_q <= 1'b0;
      out_row_q   <= '0;
      out_sum_q   <= '0;
      done        <= 1'b0;
    end else if (spmv_init) begin
      acc_live    <= 1'b0;
      acc_sum     <= '0;
      acc_row     <= '0;
      out_valid_q <= 1'b0;
      out_row_q   <= '0;
      out_sum_q   <= '0;
      done        <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      done        <= (state_q == S_DONE);
      if (state_q == S_FLUSH) begin
        out_valid_q <= 1'b1;
        out_row_q   <= acc_row;
        out_sum_q   <= acc_sum;
        acc_live    <= 1'b0;
      end else if (q_valid) begin
        if (!acc_live) begin
          acc_sum  <= q_prod;
          acc_row  <= q_row;
          acc_live <= 1'b1;
        end else if (q_row == acc_row) begin
          acc_sum <= add_res;
        end else begin
          out_valid_q <= 1'b1;
          out_row_q   <= acc_row;
          out_sum_q   <= acc_sum;
          acc_sum     <= q_prod;
          acc_row     <= q_row;
        end
      end
    end
  end

  logic [DATA_W-1:0] rl_mem [RL_DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [AW:0]       rl_count;
  logic              push_ok, pop_ok;

  assign rl_empty = (rl_count == '0);
  assign rl_full  = (rl_count == (AW+1)'(RL_DEPTH));
  assign pop_ok   = rl_pop && !rl_empty && !spmv_init;
  // A pop in the same cycle frees the slot, so a full FIFO still takes the push.
  assign push_ok  = rl_push && (!rl_full || pop_ok) && !spmv_init;
  assign rl_head  = rl_empty ? '0 : rl_mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) rl_mem[wr_ptr] <= rl_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      rl_count <= '0;
    end else if (spmv_init) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      rl_count <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      if (push_ok && !pop_ok)      rl_count <= rl_count + 1'b1;
      else if (!push_ok && pop_ok) rl_count <= rl_count - 1'b1;
    end
  end
endmodule

// File: tb/tb_spmv_lane.sv
// Directed bench for spmv_lane: row sums checked through an expected-output queue, plus FIFO/init checks.
module tb_spmv_lane;
  localparam int DATA_W     = 8;
  localparam int DIM_W      = 10;
  localparam int MUL_STAGES = 4;
  localparam int RL_DEPTH   = 4;
  localparam int EW         = DIM_W + DATA_W;

`ifdef SPMV_LANE_SAT_EN
  localparam int SAT_EXP = 127;
`else
  localparam int SAT_EXP = -56;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              spmv_init = 1'b0;
  logic              rl_push = 1'b0;
  logic              rl_pop = 1'b0;
  logic [DATA_W-1:0] rl_data = '0;
  logic [DATA_W-1:0] rl_head;
  logic              rl_empty;
  logic              rl_full;
  logic              done;
  logic [1:0]        dbg_state;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int last_out_cyc = 0;
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] mon_exp;

  spmv_lane_if #(.DATA_W(DATA_W), .DIM_W(DIM_W)) bus ();

  spmv_lane #(
    .DATA_W(DATA_W), .DIM_W(DIM_W), .MUL_STAGES(MUL_STAGES), .RL_DEPTH(RL_DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .spmv_init(spmv_init), .bus(bus),
    .rl_push(rl_push), .rl_data(rl_data), .rl_pop(rl_pop), .rl_head(rl_head),
    .rl_empty(rl_empty), .rl_full(rl_full), .done(done), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, act, exp);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (rst_n && bus.out_valid) begin
      checks++;
      last_out_cyc = cyc;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL out_unexpected got row=%0d sum=%0d exp none", bus.out_row, $signed(bus.out_sum));
      end else begin
        mon_exp = exp_q.pop_front();
        if ({bus.out_row, bus.out_sum} !== mon_exp) begin
          errors++;
          $display("FAIL out_row_sum got row=%0d sum=%0d exp row=%0d sum=%0d", bus.out_row,
                   $signed(bus.out_sum), mon_exp[EW-1:DATA_W], $signed(mon_exp[DATA_W-1:0]));
        end
      end
    end
  end

  // driver tasks
  task automatic expect_out(input int row, input int sum);
    exp_q.push_back({DIM_W'(row), DATA_W'(sum)});
  endtask

  task automatic send(input int v, input int c, input int r, input int b, input bit l);
    int t;
    bus.in_valid = 1'b1;
    bus.in_val   = DATA_W'(v);
    bus.in_col   = DIM_W'(c);
    bus.in_last  = l;
    #1;
    t = 0;
    while (!bus.in_ready && t < 20) begin
      @(negedge clk);
      #1;
      t++;
    end
    if (!bus.in_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout got in_ready=0 exp 1");
      bus.in_valid = 1'b0;
      return;
    end
    @(negedge clk);
    bus.in_valid   = 1'b0;
    bus.bvb_val    = DATA_W'(b);
    bus.dec_row_id = DIM_W'(r);
    acc_cyc = cyc;
    #1;
    check("col_out_valid", bus.col_out_valid, 1);
    check("col_out", bus.col_out, c);
  endtask

  task automatic wait_done(input int out_lat, input int done_lat);
    int t = 0;
    while (!done && t < 40) begin
      @(negedge clk);
      #1;
      t++;
    end
    check("done_seen", done, 1);
    check("done_latency", cyc - acc_cyc, done_lat);
    check("out_latency", last_out_cyc - acc_cyc, out_lat);
    check("exp_q_drained", exp_q.size(), 0);
  endtask

  task automatic do_init();
    spmv_init = 1'b1;
    #1;
    check("in_ready_during_init", bus.in_ready, 0);
    @(negedge clk);
    spmv_init = 1'b0;
    #1;
    check("in_ready_after_init", bus.in_ready, 1);
    check("done_after_init", done, 0);
  endtask

  task automatic rl_op(input bit push, input bit pop, input int d);
    @(negedge clk);
    rl_push = push;
    rl_pop  = pop;
    rl_data = DATA_W'(d);
    @(negedge clk);
    rl_push = 1'b0;
    rl_pop  = 1'b0;
    #1;
  endtask

  initial begin
    bus.in_valid   = 1'b0;
    bus.in_val     = '0;
    bus.in_col     = '0;
    bus.in_last    = 1'b0;
    bus.bvb_val    = '0;
    bus.dec_row_id = '0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_col_out_valid", bus.col_out_valid, 0);
    check("rst_col_out", bus.col_out, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_row", bus.out_row, 0);
    check("rst_out_sum", bus.out_sum, 0);
    check("rst_done", done, 0);
    check("rst_rl_empty", rl_empty, 1);
    check("rst_rl_full", rl_full, 0);
    check("rst_rl_head", rl_head, 0);
    check("rst_state", dbg_state, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // two rows back to back, first row is row 0
    expect_out(0, 26);
    expect_out(1, 7);
    send(2, 11, 0, 3, 1'b0);
    send(4, 12, 0, 5, 1'b0);
    send(7, 13, 1, 1, 1'b1);
    wait_done(MUL_STAGES + 3, MUL_STAGES + 4);
    do_init();

    // gapped input, one row
    expect_out(5, 6);
    send(1, 20, 5, 1, 1'b0);
    @(negedge clk);
    send(2, 21, 5, 1, 1'b0);
    @(negedge clk);
    send(3, 22, 5, 1, 1'b1);
    wait_done(MUL_STAGES + 3, MUL_STAGES + 4);
    do_init();

    // signed products across three rows
    expect_out(2, -15);
    expect_out(3, 8);
    expect_out(4, 81);
    send(-3, 30, 2, 5, 1'b0);
    send(6, 31, 3, -2, 1'b0);
    send(10, 32, 3, 2, 1'b0);
    send(9, 33, 4, 9, 1'b1);
    wait_done(MUL_STAGES + 3, MUL_STAGES + 4);
    do_init();

    // accumulation overflow
    expect_out(7, SAT_EXP);
    send(100, 40, 7, 1, 1'b0);
    send(100, 41, 7, 1, 1'b1);
    wait_done(MUL_STAGES + 3, MUL_STAGES + 4);
    do_init();

    // init mid-stream discards in-flight work
    send(3, 50, 1, 2, 1'b0);
    send(4, 51, 1, 2, 1'b0);
    send(5, 52, 1, 2, 1'b0);
    @(negedge clk);
    do_init();
    repeat (15) @(negedge clk);
    #1;
    check("init_no_done", done, 0);
    check("init_col_out_valid", bus.col_out_valid, 0);
    expect_out(3, 25);
    send(5, 53, 3, 5, 1'b1);
    wait_done(MUL_STAGES + 3, MUL_STAGES + 4);
    do_init();

    // row-length FIFO
    rl_op(1'b1, 1'b0, 10);
    check("rl_head_first", rl_head, 10);
    check("rl_empty_first", rl_empty, 0);
    rl_op(1'b1, 1'b0, 20);
    rl_op(1'b1, 1'b0, 30);
    rl_op(1'b1, 1'b0, 40);
    check("rl_full_4", rl_full, 1);
    rl_op(1'b1, 1'b0, 50);
    check("rl_full_5th", rl_full, 1);
    check("rl_head_5th", rl_head, 10);
    rl_op(1'b1, 1'b1, 60);
    check("rl_full_pp", rl_full, 1);
    check("rl_head_pp", rl_head, 20);
    rl_op(1'b0, 1'b1, 0);
    check("rl_head_pop1", rl_head, 30);
    rl_op(1'b0, 1'b1, 0);
    check("rl_head_pop2", rl_head, 40);
    rl_op(1'b0, 1'b1, 0);
    check("rl_head_pop3", rl_head, 60);
    check("rl_full_pop3", rl_full, 0);
    rl_op(1'b0, 1'b1, 0);
    check("rl_empty_pop4", rl_empty, 1);
    check("rl_head_pop4", rl_head, 0);
    rl_op(1'b0, 1'b1, 0);
    check("rl_empty_pop_empty", rl_empty, 1);
    rl_op(1'b1, 1'b1, 70);
    check("rl_empty_pp_empty", rl_empty, 0);
    check("rl_head_pp_empty", rl_head, 70);
    rl_op(1'b0, 1'b1, 0);
    check("rl_empty_final", rl_empty, 1);

    check("exp_q_final", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
